muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width in bits; legal values are even and at least 4.
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request strobe, sampled on the rising edge of clk.
REQ-005 fncode  input  6  R-type function code: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13.
REQ-006 op_a  input  WIDTH  rs operand (dividend, multiplicand, or MTHI/MTLO data).
REQ-007 op_b  input  WIDTH  rt operand (divisor or multiplier).
REQ-008 busy  output  1  high while an operation is in flight; start is not accepted while busy is high.
REQ-009 done  output  1  one-cycle pulse; HI/LO hold the new result while done is high.
REQ-010 hi  output  WIDTH  HI register (product upper half, or remainder).
REQ-011 lo  output  WIDTH  LO register (product lower half, or quotient).

Function
REQ-012 The FSM SHALL have states IDLE, CALC and FIN, with busy = (state != IDLE) and done = (state == FIN).
REQ-013 Accept rule: a request SHALL be accepted only when state==IDLE, start==1 and fncode is one of the six listed codes; any other fncode SHALL be ignored with no state change.
REQ-014 MTHI/MTLO SHALL write op_a into hi/lo on the accepting edge, stay in IDLE, and assert neither busy nor done.
REQ-015 MULT/MULTU/DIV/DIVU with op_b != 0 (or any multiply) SHALL latch operands on the accepting edge and enter CALC.
REQ-016 CALC SHALL run an iterative unit sequence of exactly WIDTH cycles: shift-add multiply and restoring divide, one bit per cycle, with a down-counter of clog2(WIDTH)+1 bits.
REQ-017 On the last CALC cycle, hi/lo SHALL be updated and the FSM SHALL enter FIN; FIN SHALL last exactly one cycle and then return to IDLE.
REQ-018 Latency: done SHALL be high in the (WIDTH+1)th cycle after the accepting edge; for WIDTH=32, that is 33 cycles.
REQ-019 hi/lo SHALL be unchanged from acceptance until the FIN-entry edge (no intermediate values are visible).
REQ-020 Signed operations (MULT/DIV) SHALL use magnitudes internally; for MULT, the 2*WIDTH product SHALL be negated if sign(a)^sign(b).
REQ-021 For DIV, the quotient SHALL be negated if sign(a)^sign(b), and the remainder SHALL take the sign of op_a (truncating division).
REQ-022 DIV of the most negative value by -1 SHALL give lo = 1 followed by WIDTH-1 zeros (for WIDTH=32, 0x80000000) and hi = 0, with no error indication.
REQ-023 Divide by zero (DIV/DIVU with op_b==0) SHALL skip CALC and go IDLE->FIN in one cycle, setting hi = op_a and lo = all ones, with done high in the cycle after acceptance.
REQ-024 start while busy (in CALC or FIN) SHALL be ignored entirely; it SHALL NOT be queued.
REQ-025 Back-to-back: the earliest next accept SHALL be on the edge at which the state is IDLE again, i.e. the edge after the FIN cycle.
REQ-026 Operand inputs SHALL be don't-care after the accepting edge.

Reset
REQ-027 When rst_n is low, the block SHALL immediately (asynchronously) force state=IDLE, busy=0, done=0, hi=0, lo=0, clear the counter and clear the internal operand registers.
REQ-028 Reset asserted during CALC or FIN SHALL abort the operation; no done pulse SHALL follow after rst_n is released.
REQ-029 After rst_n deasserts, the first accept SHALL be possible on the next rising edge of clk.

Verification
REQ-030 MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 MULT with a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV with a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIVU with a=100, b=0 -> done one cycle after accept, hi=100, lo=0xFFFFFFFF, busy high for exactly 1 cycle.
REQ-033 DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 MTLO a=0x1234, then during an active DIVU pulse start with MTHI -> MTLO sets lo=0x1234 with no done; the MTHI is ignored; only one done pulse occurs.
REQ-035 Pull rst_n low in CALC cycle 10 -> busy, done, hi and lo are 0 immediately, with no later done; a following MULTU 2*3 gives lo=6 after 33 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per clock.
// MTHI/MTLO write HI/LO directly; divide by zero bypasses the iteration.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       fncode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic              op_div, neg_res, neg_rem;
   logic [WIDTH-1:0]  acc_hi, acc_lo, opnd;

   logic              valid_fn, accept, sgn_op, a_neg, b_neg, is_div;
   logic [WIDTH-1:0]  mag_a, mag_b;

   assign valid_fn = (fncode == F_MULT) || (fncode == F_MULTU) || (fncode == F_DIV) ||
                     (fncode == F_DIVU) || (fncode == F_MTHI) || (fncode == F_MTLO);
   assign accept   = (state == IDLE) && start && valid_fn;
   assign is_div   = (fncode == F_DIV) || (fncode == F_DIVU);
   assign sgn_op   = (fncode == F_MULT) || (fncode == F_DIV);
   assign a_neg    = sgn_op & op_a[WIDTH-1];
   assign b_neg    = sgn_op & op_b[WIDTH-1];
   assign mag_a    = a_neg ? -op_a : op_a;
   assign mag_b    = b_neg ? -op_b : op_b;

   // One iteration step; acc_hi is partial product / partial remainder, acc_lo multiplier / quotient.
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s, res_hi, res_lo;

   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      div_ge    = div_shift >= {1'b0, opnd};
      if (op_div) begin
         step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], div_ge};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
      prod   = {step_hi, step_lo};
      prod_s = neg_res ? -prod : prod;
      quo_s  = neg_res ? -step_lo : step_lo;
      rem_s  = neg_rem ? -step_hi : step_hi;
      res_hi = op_div ? rem_s : prod_s[2*WIDTH-1:WIDTH];
      res_lo = op_div ? quo_s : prod_s[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         cnt     <= '0;
         op_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opnd    <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               if (fncode == F_MTHI) hi <= op_a;
               else if (fncode == F_MTLO) lo <= op_a;
               else if (is_div && op_b == '0) begin
                  hi    <= op_a;
                  lo    <= '1;
                  state <= FIN;
                  busy  <= 1'b1;
                  done  <= 1'b1;
               end else begin
                  state   <= CALC;
                  busy    <= 1'b1;
                  cnt     <= CW'(WIDTH);
                  op_div  <= is_div;
                  neg_res <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  acc_hi  <= '0;
                  acc_lo  <= is_div ? mag_a : mag_b;
                  opnd    <= is_div ? mag_b : mag_a;
               end
            end
            CALC: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit (WIDTH=32) against 64-bit arithmetic reference results.
module tb_muldiv_unit;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;

   logic        clk, rst_n, start, busy, done;
   logic [5:0]  fncode;
   logic [31:0] op_a, op_b, hi, lo;
   logic [31:0] mhi, mlo;
   int          checks, errors;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .fncode(fncode), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: full-width arithmetic on sign- or zero-extended operands.
   function automatic void model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el, output int elat);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa   = (fn == F_MULT || fn == F_DIV) ? longint'($signed(a)) : longint'({32'b0, a});
      sb   = (fn == F_MULT || fn == F_DIV) ? longint'($signed(b)) : longint'({32'b0, b});
      elat = 33;
      if (fn == F_MULT || fn == F_MULTU) begin
         p  = sa * sb;
         eh = p[63:32];
         el = p[31:0];
      end else if (b == 0) begin
         eh   = a;
         el   = '1;
         elat = 1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         p  = q;
         el = p[31:0];
         p  = r;
         eh = p[31:0];
      end
   endfunction

   task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, input int poke);
      logic [31:0] eh, el, oh, ol;
      int          lat, elat;
      bit          stable;
      model(fn, a, b, eh, el, elat);
      oh = hi; ol = lo; stable = 1'b1;
      fncode = fn; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op_a = $urandom; op_b = $urandom; fncode = 6'($urandom);
      lat = 1;
      while (!done && lat < 100) begin
         if (hi !== oh || lo !== ol || busy !== 1'b1) stable = 1'b0;
         if (lat == poke) begin
            start = 1'b1; fncode = F_MTHI; op_a = $urandom;
         end else start = 1'b0;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk("latency", 64'(lat), 64'(elat));
      chk("busy_at_done", {63'b0, busy}, 64'd1);
      chk("hi", {32'b0, hi}, {32'b0, eh});
      chk("lo", {32'b0, lo}, {32'b0, el});
      chk("hilo_stable", {63'b0, stable}, 64'd1);
      @(negedge clk);
      chk("single_done", {62'b0, busy, done}, 64'd0);
      mhi = eh; mlo = el;
   endtask

   task automatic do_mt(input logic [5:0] fn, input logic [31:0] a);
      fncode = fn; op_a = a; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (fn == F_MTHI) mhi = a; else mlo = a;
      chk("mt_hi", {32'b0, hi}, {32'b0, mhi});
      chk("mt_lo", {32'b0, lo}, {32'b0, mlo});
      chk("mt_flags", {62'b0, busy, done}, 64'd0);
   endtask

   initial begin
      logic [5:0] fns [4];
      logic [31:0] a, b;
      bit          seen;
      fns = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
      checks = 0; errors = 0;
      rst_n = 1'b0; start = 1'b0; fncode = '0; op_a = '0; op_b = '0;
      mhi = '0; mlo = '0;
      repeat (2) @(negedge clk);
      chk("reset_flags", {62'b0, busy, done}, 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);
      rst_n = 1'b1;

      run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
      run_op(F_MULT, -32'sd3, 32'd7, -1);
      run_op(F_DIV, -32'sd7, 32'd2, -1);
      run_op(F_DIVU, 32'd100, 32'd0, -1);
      run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, -1);
      run_op(F_DIV, -32'sd7, -32'sd2, -1);
      run_op(F_DIV, 32'd7, -32'sd2, -1);
      run_op(F_MULT, 32'h80000000, 32'h80000000, -1);
      run_op(F_DIV, 32'd5, 32'd0, -1);

      // Unknown function code is ignored.
      fncode = 6'h20; op_a = 32'hDEAD; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("bad_fn_flags", {62'b0, busy, done}, 64'd0);
      chk("bad_fn_hilo", {hi, lo}, {mhi, mlo});

      do_mt(F_MTLO, 32'h1234);
      run_op(F_DIVU, 32'd1000, 32'd7, 5);
      do_mt(F_MTHI, 32'hCAFEF00D);

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         run_op(fns[$urandom_range(0, 3)], a, b, (i % 5 == 0) ? int'($urandom_range(1, 32)) : -1);
      end

      // Abort in CALC cycle 10.
      fncode = F_MULTU; op_a = 32'h00012345; op_b = 32'h00000777; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_flags", {62'b0, busy, done}, 64'd0);
      chk("async_rst_hilo", {hi, lo}, 64'd0);
      mhi = '0; mlo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      do_mt(F_MTLO, 32'h55);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("no_done_after_abort", {63'b0, seen}, 64'd0);
      run_op(F_MULTU, 32'd2, 32'd3, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
